// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: shared types and constants for the dsp_mac_seq multiply-accumulate
// slice.
//   mac_state_e  - burst sequencer states.
//   DEF_*        - default widths, depth and mode for the slice.
//   sat_bound()  - two's-complement max/min bound for a given width.
package dsp_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } mac_state_e;

    localparam int DEF_AW       = 18;
    localparam int DEF_BW       = 18;
    localparam int DEF_PW       = 48;
    localparam int DEF_NTAP_MAX = 16;
    localparam int DEF_PIPE_M   = 1;
    localparam int DEF_SAT_EN   = 0;

    // Widest accumulator the bound helper can describe.
    localparam int SAT_MAX_W = 256;

    // Bound for a pw-bit signed value: neg=0 -> +2^(pw-1)-1, neg=1 -> -2^(pw-1).
    // Bits above pw-1 are zero; callers keep only the low pw bits.
    function automatic logic [SAT_MAX_W-1:0] sat_bound(input int pw, input logic neg);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i == pw - 1) begin
                v[i] = neg;
            end else if (i < pw - 1) begin
                v[i] = ~neg;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/dsp_mac_seq_if.sv
// dsp_mac_seq_if: sample-in / result-out bundle of the dsp_mac_seq slice.
//   in_valid/in_ready     - sample handshake (A, B, D, C, use_pre, pre_sub, acc_len)
//   out_valid/out_ready   - result handshake (P, CARRYOUT, OVF)
//   master modport: sample source / result sink side.
//   slave  modport: the MAC slice.
interface dsp_mac_seq_if
    import dsp_mac_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int BW       = DEF_BW,
    parameter int PW       = DEF_PW,
    parameter int NTAP_MAX = DEF_NTAP_MAX
);
    localparam int LENW = $clog2(NTAP_MAX + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [AW-1:0] A;
    logic signed [BW-1:0] B;
    logic signed [BW-1:0] D;
    logic signed [PW-1:0] C;
    logic                 use_pre;
    logic                 pre_sub;
    logic [LENW-1:0]      acc_len;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [PW-1:0] P;
    logic                 CARRYOUT;
    logic                 OVF;

    modport master (
        output in_valid, A, B, D, C, use_pre, pre_sub, acc_len, out_ready,
        input  in_ready, out_valid, P, CARRYOUT, OVF
    );

    modport slave (
        input  in_valid, A, B, D, C, use_pre, pre_sub, acc_len, out_ready,
        output in_ready, out_valid, P, CARRYOUT, OVF
    );

endinterface

// File: rtl/dsp_mac_dp.sv
// dsp_mac_dp: datapath of the MAC slice.
//   Stage p0: input registers (operands, seed, controls, first/last markers).
//   Stage p1: product register when PIPE_M=1, otherwise a wire from p0.
//   Stage p2: accumulator with carry, sticky overflow and optional saturation.
// Ports:
//   CLK, RST_N              clock, async active-low reset
//   in_vld, first, last     accepted-sample strobe and burst markers
//   a, b, d, c              operands and burst seed
//   use_pre, pre_sub        pre-adder controls
//   acc, carry, ovf         accumulator state
//   done                    one-cycle pulse when the last product has retired
module dsp_mac_dp
    import dsp_mac_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int BW     = DEF_BW,
    parameter int PW     = DEF_PW,
    parameter int PIPE_M = DEF_PIPE_M,
    parameter int SAT_EN = DEF_SAT_EN
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 in_vld,
    input  logic                 first,
    input  logic                 last,
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    input  logic signed [BW-1:0] d,
    input  logic signed [PW-1:0] c,
    input  logic                 use_pre,
    input  logic                 pre_sub,
    output logic signed [PW-1:0] acc,
    output logic                 carry,
    output logic                 ovf,
    output logic                 done
);
    localparam int MW = AW + BW;

    function automatic logic signed [PW-1:0] sat_value(input logic neg);
        logic [SAT_MAX_W-1:0] full;
        full = sat_bound(PW, neg);
        return full[PW-1:0];
    endfunction

    // ---- stage p0: input registers ----
    logic                 vld_p0, first_p0, last_p0, use_pre_p0, pre_sub_p0;
    logic signed [AW-1:0] a_p0;
    logic signed [BW-1:0] b_p0, d_p0;
    logic signed [PW-1:0] c_p0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p0     <= 1'b0;
            first_p0   <= 1'b0;
            last_p0    <= 1'b0;
            use_pre_p0 <= 1'b0;
            pre_sub_p0 <= 1'b0;
            a_p0       <= '0;
            b_p0       <= '0;
            d_p0       <= '0;
            c_p0       <= '0;
        end else begin
            vld_p0 <= in_vld;
            if (in_vld) begin
                first_p0   <= first;
                last_p0    <= last;
                use_pre_p0 <= use_pre;
                pre_sub_p0 <= pre_sub;
                a_p0       <= a;
                b_p0       <= b;
                d_p0       <= d;
                c_p0       <= c;
            end
        end
    end

    // Pre-adder wraps at BW bits; product is sign-extended to the accumulator width.
    logic signed [BW-1:0] pre_p0;
    logic signed [MW-1:0] m_p0;
    logic signed [PW-1:0] mext_p0;

    always_comb begin
        if (!use_pre_p0) begin
            pre_p0 = b_p0;
        end else if (pre_sub_p0) begin
            pre_p0 = d_p0 - b_p0;
        end else begin
            pre_p0 = d_p0 + b_p0;
        end
        m_p0    = MW'(a_p0) * MW'(pre_p0);
        mext_p0 = PW'(m_p0);
    end

    // ---- stage p1: optional product register ----
    logic                 vld_p1, first_p1, last_p1;
    logic signed [PW-1:0] m_p1, c_p1;

    if (PIPE_M != 0) begin : g_mreg
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                vld_p1   <= 1'b0;
                first_p1 <= 1'b0;
                last_p1  <= 1'b0;
                m_p1     <= '0;
                c_p1     <= '0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    first_p1 <= first_p0;
                    last_p1  <= last_p0;
                    m_p1     <= mext_p0;
                    c_p1     <= c_p0;
                end
            end
        end
    end else begin : g_nomreg
        assign vld_p1   = vld_p0;
        assign first_p1 = first_p0;
        assign last_p1  = last_p0;
        assign m_p1     = mext_p0;
        assign c_p1     = c_p0;
    end

    // ---- stage p2: accumulator ----
    logic signed [PW-1:0] acc_p2, acc_in;
    logic [PW:0]          sum;
    logic                 step_ovf, sat_p2, ovf_p2, carry_p2, done_p2;

    always_comb begin
        acc_in   = first_p1 ? c_p1 : acc_p2;
        sum      = {1'b0, acc_in} + {1'b0, m_p1};
        step_ovf = (acc_in[PW-1] == m_p1[PW-1]) && (sum[PW-1] != acc_in[PW-1]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_p2   <= '0;
            sat_p2   <= 1'b0;
            ovf_p2   <= 1'b0;
            carry_p2 <= 1'b0;
            done_p2  <= 1'b0;
        end else begin
            done_p2 <= vld_p1 && last_p1;
            if (vld_p1) begin
                carry_p2 <= sum[PW];
                ovf_p2   <= step_ovf || (!first_p1 && ovf_p2);
                if ((SAT_EN != 0) && !first_p1 && sat_p2) begin
                    // Once clamped, the result stays pinned for the rest of the burst.
                    acc_p2 <= acc_p2;
                end else if ((SAT_EN != 0) && step_ovf) begin
                    // Both operands share a sign, so that sign is the overflow direction.
                    acc_p2 <= sat_value(acc_in[PW-1]);
                    sat_p2 <= 1'b1;
                end else begin
                    acc_p2 <= sum[PW-1:0];
                    sat_p2 <= 1'b0;
                end
            end
        end
    end

    assign acc   = acc_p2;
    assign carry = carry_p2;
    assign ovf   = ovf_p2;
    assign done  = done_p2;

endmodule

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: pre-add / multiply / accumulate slice with a burst sequencer.
// A burst of acc_len products (0 -> 1, above NTAP_MAX -> NTAP_MAX) is summed
// onto the seed C and presented as one result on P with CARRYOUT and OVF.
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    dsp_mac_seq_if.slave (sample in, result out, both valid/ready)
module dsp_mac_seq
    import dsp_mac_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int BW       = DEF_BW,
    parameter int PW       = DEF_PW,
    parameter int NTAP_MAX = DEF_NTAP_MAX,
    parameter int PIPE_M   = DEF_PIPE_M,
    parameter int SAT_EN   = DEF_SAT_EN
) (
    input logic         CLK,
    input logic         RST_N,
    dsp_mac_seq_if.slave bus
);
    localparam int              LENW    = $clog2(NTAP_MAX + 1);
    localparam logic [LENW-1:0] LEN_MAX = LENW'(NTAP_MAX);
    localparam logic [LENW-1:0] LEN_ONE = LENW'(1);

    mac_state_e           state, state_nxt;
    logic [LENW-1:0]      len_q, len_nxt, cnt_q, cnt_nxt, len_in;
    logic                 in_ready_q, accept, first, last, load_out;
    logic signed [PW-1:0] acc, p_q;
    logic                 acc_carry, acc_ovf, acc_done, co_q, ovf_q;

    always_comb begin
        if (bus.acc_len == '0) begin
            len_in = LEN_ONE;
        end else if (bus.acc_len > LEN_MAX) begin
            len_in = LEN_MAX;
        end else begin
            len_in = bus.acc_len;
        end
    end

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        cnt_nxt   = cnt_q;
        first     = 1'b0;
        last      = 1'b0;
        load_out  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    first   = 1'b1;
                    len_nxt = len_in;
                    cnt_nxt = LEN_ONE;
                    if (len_in == LEN_ONE) begin
                        last      = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    cnt_nxt = cnt_q + LEN_ONE;
                    if (cnt_q == len_q - LEN_ONE) begin
                        last      = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (acc_done) begin
                    load_out  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready is registered from the next state so it is low throughout reset
    // and never rises in the same cycle as a result handshake.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            p_q        <= '0;
            co_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            len_q      <= len_nxt;
            cnt_q      <= cnt_nxt;
            in_ready_q <= (state_nxt == IDLE) || (state_nxt == ACCUM);
            if (load_out) begin
                p_q   <= acc;
                co_q  <= acc_carry;
                ovf_q <= acc_ovf;
            end
        end
    end

    dsp_mac_dp #(
        .AW     (AW),
        .BW     (BW),
        .PW     (PW),
        .PIPE_M (PIPE_M),
        .SAT_EN (SAT_EN)
    ) u_dp (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .in_vld  (accept),
        .first   (first),
        .last    (last),
        .a       (bus.A),
        .b       (bus.B),
        .d       (bus.D),
        .c       (bus.C),
        .use_pre (bus.use_pre),
        .pre_sub (bus.pre_sub),
        .acc     (acc),
        .carry   (acc_carry),
        .ovf     (acc_ovf),
        .done    (acc_done)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state == HOLD);
    assign bus.P         = p_q;
    assign bus.CARRYOUT  = co_q;
    assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: directed bench for dsp_mac_seq. Three instances: the default
// slice (PW=48, PIPE_M=1, wrap), a 40-bit saturating slice without product
// register, and a 40-bit wrapping slice with product register.
module tb_dsp_mac_seq;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    dsp_mac_seq_if #(.AW(18), .BW(18), .PW(48), .NTAP_MAX(16)) m_if ();
    dsp_mac_seq_if #(.AW(18), .BW(18), .PW(40), .NTAP_MAX(16)) s_if ();
    dsp_mac_seq_if #(.AW(18), .BW(18), .PW(40), .NTAP_MAX(16)) w_if ();

    dsp_mac_seq #(.AW(18), .BW(18), .PW(48), .NTAP_MAX(16), .PIPE_M(1), .SAT_EN(0))
        u_main (.CLK(CLK), .RST_N(RST_N), .bus(m_if.slave));
    dsp_mac_seq #(.AW(18), .BW(18), .PW(40), .NTAP_MAX(16), .PIPE_M(0), .SAT_EN(1))
        u_sat (.CLK(CLK), .RST_N(RST_N), .bus(s_if.slave));
    dsp_mac_seq #(.AW(18), .BW(18), .PW(40), .NTAP_MAX(16), .PIPE_M(1), .SAT_EN(0))
        u_wrap (.CLK(CLK), .RST_N(RST_N), .bus(w_if.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Present one sample to the main slice and return once it has been accepted.
    task automatic send_main(input int a, input int b, input int d, input longint c,
                             input bit up, input bit ps, input int len, output int waited);
        waited       = 0;
        m_if.A       = 18'(a);
        m_if.B       = 18'(b);
        m_if.D       = 18'(d);
        m_if.C       = 48'(c);
        m_if.use_pre = up;
        m_if.pre_sub = ps;
        m_if.acc_len = 5'(len);
        m_if.in_valid = 1'b1;
        while (!m_if.in_ready && waited < 20) begin
            @(posedge CLK); #1;
            waited++;
        end
        @(posedge CLK); #1;
        m_if.in_valid = 1'b0;
    endtask

    task automatic wait_main(output int n);
        n = 0;
        while (!m_if.out_valid && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    // Wait for the result of a burst whose last sample was just accepted,
    // check it, then complete the output handshake.
    task automatic expect_main(input string tag, input longint p, input bit co, input bit ov);
        int n;
        wait_main(n);
        check_eq({tag, "_lat"}, n, 3);
        check_eq({tag, "_P"}, m_if.P, p);
        check_eq({tag, "_CO"}, m_if.CARRYOUT, co);
        check_eq({tag, "_OVF"}, m_if.OVF, ov);
        m_if.out_ready = 1'b1;
        @(posedge CLK); #1;
        m_if.out_ready = 1'b0;
        check_eq({tag, "_vld_clr"}, m_if.out_valid, 0);
    endtask

    // Same sample to the saturating and wrapping slices.
    task automatic send_ov(input int a, input int b, input longint c, input int len);
        int g;
        g = 0;
        s_if.A = 18'(a); s_if.B = 18'(b); s_if.D = '0; s_if.C = 40'(c);
        w_if.A = 18'(a); w_if.B = 18'(b); w_if.D = '0; w_if.C = 40'(c);
        s_if.use_pre = 1'b0; s_if.pre_sub = 1'b0; s_if.acc_len = 5'(len);
        w_if.use_pre = 1'b0; w_if.pre_sub = 1'b0; w_if.acc_len = 5'(len);
        s_if.in_valid = 1'b1;
        w_if.in_valid = 1'b1;
        while (!(s_if.in_ready && w_if.in_ready) && g < 20) begin
            @(posedge CLK); #1;
            g++;
        end
        check_eq("ov_send_wait", g, 0);
        @(posedge CLK); #1;
        s_if.in_valid = 1'b0;
        w_if.in_valid = 1'b0;
    endtask

    task automatic expect_ov(input string tag, input longint ps, input longint pw,
                             input bit co, input bit ov);
        int ks, kw;
        ks = 0;
        kw = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK); #1;
            if (s_if.out_valid && ks == 0) ks = k;
            if (w_if.out_valid && kw == 0) kw = k;
        end
        check_eq({tag, "_sat_lat"}, ks, 2);
        check_eq({tag, "_wrap_lat"}, kw, 3);
        check_eq({tag, "_sat_P"}, s_if.P, ps);
        check_eq({tag, "_sat_OVF"}, s_if.OVF, ov);
        check_eq({tag, "_sat_CO"}, s_if.CARRYOUT, co);
        check_eq({tag, "_wrap_P"}, w_if.P, pw);
        check_eq({tag, "_wrap_OVF"}, w_if.OVF, ov);
        check_eq({tag, "_wrap_CO"}, w_if.CARRYOUT, co);
        s_if.out_ready = 1'b1;
        w_if.out_ready = 1'b1;
        @(posedge CLK); #1;
        s_if.out_ready = 1'b0;
        w_if.out_ready = 1'b0;
    endtask

    initial begin
        int     w, n, wsum, xfer, kseen;
        longint two39;
        two39 = longint'(1) << 39;

        m_if.in_valid = 1'b0; m_if.out_ready = 1'b0;
        m_if.A = '0; m_if.B = '0; m_if.D = '0; m_if.C = '0;
        m_if.use_pre = 1'b0; m_if.pre_sub = 1'b0; m_if.acc_len = '0;
        s_if.in_valid = 1'b0; s_if.out_ready = 1'b0;
        s_if.A = '0; s_if.B = '0; s_if.D = '0; s_if.C = '0;
        s_if.use_pre = 1'b0; s_if.pre_sub = 1'b0; s_if.acc_len = '0;
        w_if.in_valid = 1'b0; w_if.out_ready = 1'b0;
        w_if.A = '0; w_if.B = '0; w_if.D = '0; w_if.C = '0;
        w_if.use_pre = 1'b0; w_if.pre_sub = 1'b0; w_if.acc_len = '0;

        // Power-on reset
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_vld", m_if.out_valid, 0);
        check_eq("rst_rdy", m_if.in_ready, 0);
        check_eq("rst_P", m_if.P, 0);
        check_eq("rst_OVF", m_if.OVF, 0);
        check_eq("rst_CO", m_if.CARRYOUT, 0);
        RST_N = 1'b1;
        check_eq("rel_rdy0", m_if.in_ready, 0);
        @(posedge CLK); #1;
        check_eq("rel_rdy1", m_if.in_ready, 1);

        // Single tap: pre = 3+5 = 8, M = 16, P = 4+16
        send_main(2, 5, 3, 4, 1'b1, 1'b0, 1, w);
        check_eq("tap1_wait", w, 0);
        expect_main("tap1", 20, 1'b0, 1'b0);

        // Three taps with subtract: M = -25, 2, 0 onto C=8
        send_main(5, 9, 4, 8, 1'b1, 1'b1, 3, w);
        send_main(1, 1, 3, 8, 1'b1, 1'b1, 3, w);
        send_main(2, 2, 2, 8, 1'b1, 1'b1, 3, w);
        check_eq("tap3_rdy", m_if.in_ready, 0);
        expect_main("tap3", -15, 1'b0, 1'b0);

        // Carry: -1 + 1 carries out of the top bit, no signed overflow
        send_main(1, 1, 0, -1, 1'b0, 1'b0, 1, w);
        expect_main("carry", 0, 1'b1, 1'b0);

        // Bubbles: products 10,20,30,40 with idle cycles between samples
        for (int i = 0; i < 4; i++) begin
            send_main(i + 1, 10, 0, 0, 1'b0, 1'b0, 4, w);
            if (i < 3) begin
                repeat ((i % 2) + 1) begin
                    @(posedge CLK); #1;
                    check_eq("bub_rdy", m_if.in_ready, 1);
                end
            end
        end
        wait_main(n);
        check_eq("bub_lat", n, 3);
        // Backpressure: result must hold while out_ready is low
        for (int k = 0; k < 5; k++) begin
            check_eq("hold_P", m_if.P, 100);
            check_eq("hold_vld", m_if.out_valid, 1);
            check_eq("hold_rdy", m_if.in_ready, 0);
            @(posedge CLK); #1;
        end
        m_if.out_ready = 1'b1;
        @(posedge CLK); #1;
        check_eq("xfer_vld_clr", m_if.out_valid, 0);
        check_eq("xfer_rdy", m_if.in_ready, 1);

        // acc_len=0 behaves as a single tap; out_ready stays high throughout
        send_main(3, 4, 0, 0, 1'b0, 1'b0, 0, w);
        check_eq("len0_wait", w, 0);
        xfer  = 0;
        kseen = 0;
        for (int k = 0; k < 8; k++) begin
            if (m_if.out_valid) begin
                xfer++;
                if (kseen == 0) kseen = k;
                check_eq("len0_P", m_if.P, 12);
            end
            @(posedge CLK); #1;
        end
        check_eq("len0_xfers", xfer, 1);
        check_eq("len0_lat", kseen, 3);
        m_if.out_ready = 1'b0;

        // acc_len=NTAP_MAX: sixteen accepts, then in_ready drops
        wsum = 0;
        for (int i = 0; i < 16; i++) begin
            send_main(1, 1, 0, 5, 1'b0, 1'b0, 16, w);
            wsum += w;
        end
        check_eq("len16_wait", wsum, 0);
        check_eq("len16_rdy", m_if.in_ready, 0);
        expect_main("len16", 21, 1'b0, 1'b0);

        // Reset in the middle of a burst discards everything
        send_main(7, 7, 0, 0, 1'b0, 1'b0, 4, w);
        send_main(7, 7, 0, 0, 1'b0, 1'b0, 4, w);
        #2;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("mid_rst_vld", m_if.out_valid, 0);
        check_eq("mid_rst_rdy", m_if.in_ready, 0);
        check_eq("mid_rst_P", m_if.P, 0);
        check_eq("mid_rst_OVF", m_if.OVF, 0);
        check_eq("mid_rst_CO", m_if.CARRYOUT, 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check_eq("mid_rel_rdy", m_if.in_ready, 1);
        send_main(2, 5, 3, 4, 1'b1, 1'b0, 1, w);
        expect_main("post_rst", 20, 1'b0, 1'b0);

        // Overflow: (2^39-10) + 100 in a 40-bit accumulator
        send_ov(10, 10, two39 - 10, 1);
        expect_ov("ov1", two39 - 1, 90 - two39, 1'b0, 1'b1);

        // Overflow then a negative product: saturating result stays clamped
        send_ov(10, 10, two39 - 10, 2);
        send_ov(1, -1000, two39 - 10, 2);
        expect_ov("ov2", two39 - 1, two39 - 910, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
